lsu_bus_ctrl: RTL and testbench
===============================

// Module: lsu_bus_ctrl
// PURPOSE
//   Multi-cycle load/store controller between the execute stage and the data-memory bus.
//   Accepts one access per handshake, drives a valid/ready memory bus, and waits for the read/ack beat.
//   Returns aligned, sign/zero-extended load data, or a store ack, to the writeback stage.
//   Replaces the combinational pmem_read/pmem_write path so that memory latency is variable.
// PARAMETERS
//   TIMEOUT_CYC  255  max cycles from entering ISSUE to mem_rvalid before the access is aborted with an error
//   CNT_W        8    width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//   clk           in   1   single clock, rising edge
//   rst           in   1   synchronous, active-high reset
//   req_valid     in   1   access request from the execute stage
//   req_ready     out  1   controller idle and able to accept a request
//   req_addr      in   32  byte address (execute-stage result)
//   req_wdata     in   32  store data, unshifted (rs2)
//   req_wen       in   1   1=store, 0=load
//   req_size      in   2   0=byte, 1=half, 2=word; 3 is reserved
//   req_unsigned  in   1   load zero-extends when 1 (lbu/lhu)
//   rsp_valid     out  1   response available to writeback
//   rsp_ready     in   1   writeback consumes the response
//   rsp_rdata     out  32  extended load data; 0 for stores and errors
//   rsp_err       out  1   timeout, misalign (option) or reserved size
//   mem_valid     out  1   bus request
//   mem_ready     in   1   bus accepts the request
//   mem_addr      out  32  word-aligned address {req_addr[31:2],2'b00}
//   mem_wen       out  1   bus write
//   mem_wdata     out  32  store data shifted to the byte lane
//   mem_wmask     out  4   byte-enable mask
//   mem_rvalid    in   1   read-data / write-ack beat
//   mem_rdata     in   32  raw word read data
// BEHAVIOUR
//   - FSM states: IDLE, ISSUE, WAIT, RESP. Each state is one-hot registered; all outputs are decoded from registered state and latched fields only.
//   - Reset: state=IDLE, counter=0, all latched fields=0.
//     - While rst=1, every output is 0, including req_ready.
//     - req_ready=1 from the first cycle after rst falls.
//   - IDLE: req_ready=1.
//     - On req_valid, latch addr, wdata, wen, size and unsigned, clear the counter, and go to ISSUE.
//     - Reserved size (3): go to RESP with rsp_err=1 and make no bus access.
//   - ISSUE: mem_valid=1 with stable addr, wen, wdata and wmask until mem_ready. The cycle mem_valid&mem_ready holds, go to WAIT.
//   - WAIT: hold for mem_rvalid.
//     - Loads capture mem_rdata; stores treat the beat as an ack.
//     - On the beat, go to RESP with err=0.
//   - Timeout: the counter increments every cycle in ISSUE and WAIT.
//     - When counter==TIMEOUT_CYC and no completing beat arrives that cycle, go to RESP with err=1 and rdata=0.
//     - A beat in the same cycle as the timeout wins: err=0.
//   - RESP: rsp_valid=1 with stable rdata and err until rsp_ready, then go to IDLE.
//     - The response is held indefinitely under backpressure.
//     - req_ready=0 in every state other than IDLE, so there is no overlap of transactions.
//   - mem_rvalid is ignored outside WAIT, including stale beats after a reset or a timeout.
//   - Latency: with zero-wait mem_ready, a same-cycle-after mem_rvalid beat and rsp_ready=1, the request handshake to rsp_valid takes 3 cycles, and IDLE is re-entered on cycle 4.
//   - Store lane steering (off=addr[1:0]):
//     - byte: mask=4'b0001<<off, wdata=wdata[7:0]<<(8*off).
//     - half: mask=4'b0011<<off, wdata=wdata[15:0]<<(8*off).
//     - word: mask=4'b1111, wdata unshifted.
//     - Mask bits shifted past bit 3 are dropped (truncate to 4).
//   - Load extraction: shifted=mem_rdata>>(8*off). Then take a byte or half of shifted and sign-extend from bit 7/15, or zero-extend when unsigned. Word passes through.
//   - Reset mid-transaction: the access is abandoned, no response is produced, and any outstanding bus beat is dropped.
// CONFIGURATION
//   LSU_MISALIGN_TRAP_EN
//     - defined: in IDLE, half with addr[0]!=0 or word with addr[1:0]!=0 goes straight to RESP with rsp_err=1, rdata=0, and no bus access.
//     - undefined: misaligned accesses are issued with the truncated mask and shifted data above; rsp_err is never set for misalignment.
// STRUCTURE
//   - Package lsu_pkg holds:
//     - state enum (IDLE/ISSUE/WAIT/RESP)
//     - size encodings SZ_B/SZ_H/SZ_W
//     - functions wmask_gen(size,off) and wdata_shift(size,off,data)
//   - Sub-module lsu_load_align: combinational (rdata, off, size, unsigned) -> extended load data. Instantiated once on the WAIT capture path.
// TESTING
//   - lw at 0x8000_0004, mem_rdata=0xDEAD_BEEF, zero-wait bus -> rsp_rdata=0xDEAD_BEEF, err=0, rsp_valid 3 cycles after the request handshake.
//   - lb at 0x8000_0003, mem_rdata=0x80FF_0000 -> rsp_rdata=0xFFFF_FF80. lbu at the same address -> rsp_rdata=0x0000_0080.
//   - sh at 0x8000_0002, wdata=0x1234_ABCD -> mem_addr=0x8000_0000, mem_wmask=4'b1100, mem_wdata=0xABCD_0000, mem_wen=1.
//   - mem_ready held 0 for 300 cycles -> rsp_valid with rsp_err=1 after TIMEOUT_CYC; a later mem_rvalid is ignored and req_ready=1 after the response.
//   - rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_rdata stable throughout. rst pulsed in WAIT -> IDLE next cycle with no rsp_valid.
//   - lw at 0x8000_0001 -> with LSU_MISALIGN_TRAP_EN: err=1 and mem_valid never asserted; without it: mem_wmask irrelevant, rdata=mem_rdata>>8.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and lane-steering helpers for the load/store bus controller.
// LSU_MISALIGN_TRAP_EN (optional) makes misaligned half/word accesses fail instead of issuing.
package lsu_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        WAIT  = 4'b0100,
        RESP  = 4'b1000
    } lsu_state_e;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_RSV = 2'd3;

    // Byte enables; lanes shifted past bit 3 fall off the 4-bit result.
    function automatic logic [3:0] wmask_gen(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            SZ_B:    mask = 4'b0001 << off;
            SZ_H:    mask = 4'b0011 << off;
            SZ_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] wdata_shift(input logic [1:0] size, input logic [1:0] off,
                                                input logic [31:0] data);
        logic [4:0]  sh;
        logic [31:0] res;
        sh = {off, 3'b000};
        case (size)
            SZ_B:    res = {24'h000000, data[7:0]} << sh;
            SZ_H:    res = {16'h0000, data[15:0]} << sh;
            SZ_W:    res = data;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic res;
        case (size)
            SZ_H:    res = off[0];
            SZ_W:    res = (off != 2'b00);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data extraction: shift the raw bus word down to the addressed byte,
// then pick byte/half/word and sign- or zero-extend.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic [31:0] ext_data
);

    logic [31:0] shifted_s;

    assign shifted_s = rdata >> {off, 3'b000};

    // Width select and extension of the shifted word.
    always_comb begin
        ext_data = 32'h0000_0000;
        case (size)
            SZ_B: begin
                if (unsigned_ld) begin
                    ext_data = {24'h000000, shifted_s[7:0]};
                end else begin
                    ext_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SZ_H: begin
                if (unsigned_ld) begin
                    ext_data = {16'h0000, shifted_s[15:0]};
                end else begin
                    ext_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            SZ_W:    ext_data = shifted_s;
            default: ext_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Multi-cycle load/store controller: execute-stage handshake -> valid/ready memory bus -> writeback.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses without a bus cycle.
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

    lsu_state_e       state_r;
    lsu_state_e       state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic             wen_r;
    logic [1:0]       size_r;
    logic             uns_r;
    logic [31:0]      rsp_rdata_r;
    logic             rsp_err_r;
    logic             bad_req_s;
    logic             timeout_s;
    logic             run_s;
    logic [31:0]      load_data_s;

    assign timeout_s = (cnt_r == TIMEOUT_V);
    assign run_s     = ~rst;

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad_req_s = (req_size == SZ_RSV) || misaligned(req_size, req_addr[1:0]);
`else
    assign bad_req_s = (req_size == SZ_RSV);
`endif

    lsu_load_align u_load_align (
        .rdata       (mem_rdata),
        .off         (addr_r[1:0]),
        .size        (size_r),
        .unsigned_ld (uns_r),
        .ext_data    (load_data_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; in ISSUE a timeout abandons the request even if the bus accepts it.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nx_s = bad_req_s ? RESP : ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                if (timeout_s) begin
                    state_nx_s = RESP;
                end else if (mem_ready) begin
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = ISSUE;
                end
            end
            WAIT: begin
                if (mem_rvalid || timeout_s) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Request capture, timeout counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= {CNT_W{1'b0}};
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            wen_r       <= 1'b0;
            size_r      <= 2'b00;
            uns_r       <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        wen_r       <= req_wen;
                        size_r      <= req_size;
                        uns_r       <= req_unsigned;
                        cnt_r       <= {CNT_W{1'b0}};
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_err_r   <= bad_req_s;
                    end
                end
                ISSUE: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (timeout_s) begin
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_err_r   <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    // The beat wins over a simultaneous timeout.
                    if (mem_rvalid) begin
                        rsp_rdata_r <= wen_r ? 32'h0000_0000 : load_data_s;
                        rsp_err_r   <= 1'b0;
                    end else if (timeout_s) begin
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_err_r   <= 1'b1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Outputs come from registered state and latched fields, forced low while in reset.
    assign req_ready = run_s & (state_r == IDLE);
    assign rsp_valid = run_s & (state_r == RESP);
    assign rsp_rdata = {32{run_s}} & rsp_rdata_r;
    assign rsp_err   = run_s & (state_r == RESP) & rsp_err_r;
    assign mem_valid = run_s & (state_r == ISSUE);
    assign mem_addr  = {32{run_s}} & {addr_r[31:2], 2'b00};
    assign mem_wen   = run_s & wen_r;
    assign mem_wdata = {32{run_s}} & wdata_shift(size_r, addr_r[1:0], wdata_r);
    assign mem_wmask = {4{run_s}} & wmask_gen(size_r, addr_r[1:0]);

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: vector table plus scoreboard, with
// hand-written sequences for timeout, backpressure and mid-transaction reset.
module tb_lsu_bus_ctrl;

    localparam int TIMEOUT_CYC = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    lsu_bus_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wen(req_wen), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] mrd;       // word the bus returns
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        bus;       // a bus request is expected
        logic        lane;      // mask/wdata are meaningful
        logic [31:0] maddr;
        logic [3:0]  mask;
        logic [31:0] mwdata;
        int          lat;       // cycles from handshake edge to rsp_valid
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: zero-wait bus; 1: mem_ready never; 2: beat exactly on the timeout cycle.
    task automatic run_vec(input vec_t v, input int mode, input int bp, input string tag);
        int   cyc;
        logic pend;
        logic rv;
        logic saw_bus;
        exp_t e;
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_wen      = v.wen;
        req_size     = v.size;
        req_unsigned = v.uns;
        rsp_ready    = (bp == 0);
        tick();
        req_valid = 1'b0;
        sb.push_back('{v.exp_rdata, v.exp_err});
        cyc = 0;
        pend = 1'b0;
        saw_bus = 1'b0;
        while (!rsp_valid && cyc < 400) begin
            if (mem_valid && !saw_bus) begin
                saw_bus = 1'b1;
                check({tag, ".mem_addr"}, mem_addr, v.maddr);
                check({tag, ".mem_wen"}, 32'(mem_wen), 32'(v.wen));
                if (v.lane) begin
                    check({tag, ".mem_wmask"}, 32'(mem_wmask), 32'(v.mask));
                    check({tag, ".mem_wdata"}, mem_wdata, v.mwdata);
                end
            end
            mem_ready  = (mode != 1) && mem_valid;
            rv         = (mode == 2) ? (cyc == TIMEOUT_CYC) : pend;
            mem_rvalid = rv;
            mem_rdata  = rv ? v.mrd : 32'h0000_0000;
            pend       = mem_valid && mem_ready;
            tick();
            cyc++;
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0000_0000;
        check({tag, ".bus_used"}, 32'(saw_bus), 32'(v.bus));
        check({tag, ".latency"}, 32'(cyc + 1), 32'(v.lat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e = '{32'hxxxx_xxxx, 1'bx};
        end
        check({tag, ".rsp_rdata"}, rsp_rdata, e.rdata);
        check({tag, ".rsp_err"}, 32'(rsp_err), 32'(e.err));
        for (int i = 0; i < bp; i++) begin
            tick();
            check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".hold_rdata"}, rsp_rdata, e.rdata);
        end
        rsp_ready = 1'b1;
        tick();
        check({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv;
        //         addr          wdata         wen   sz    uns   mrd           exp_rdata     err   bus   lane  maddr         mask     mwdata        lat
        vecs[0]  = '{32'h8000_0004, 32'h0000_0000, 1'b0, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 32'h8000_0004, 4'b1111, 32'h0000_0000, 3};
        vecs[1]  = '{32'h8000_0003, 32'h0000_0000, 1'b0, 2'd0, 1'b0, 32'h80FF_0000, 32'hFFFF_FF80, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b1000, 32'h0000_0000, 3};
        vecs[2]  = '{32'h8000_0003, 32'h0000_0000, 1'b0, 2'd0, 1'b1, 32'h80FF_0000, 32'h0000_0080, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b1000, 32'h0000_0000, 3};
        vecs[3]  = '{32'h8000_0002, 32'h1234_ABCD, 1'b1, 2'd1, 1'b0, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b1100, 32'hABCD_0000, 3};
        vecs[4]  = '{32'h8000_0001, 32'h0000_00A5, 1'b1, 2'd0, 1'b0, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b0010, 32'h0000_A500, 3};
        vecs[5]  = '{32'h8000_0002, 32'h0000_0000, 1'b0, 2'd1, 1'b0, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b1100, 32'h0000_0000, 3};
        vecs[6]  = '{32'h8000_0000, 32'h0000_0000, 1'b0, 2'd1, 1'b1, 32'h1234_F00D, 32'h0000_F00D, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b0011, 32'h0000_0000, 3};
        vecs[7]  = '{32'h8000_0008, 32'hCAFE_F00D, 1'b1, 2'd2, 1'b0, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h8000_0008, 4'b1111, 32'hCAFE_F00D, 3};
        vecs[8]  = '{32'h8000_0000, 32'h0000_0000, 1'b0, 2'd3, 1'b0, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1};
        vecs[11] = '{32'h8000_0007, 32'h1234_56C3, 1'b1, 2'd0, 1'b0, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h8000_0004, 4'b1000, 32'hC300_0000, 3};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[9]  = '{32'h8000_0001, 32'h0000_0000, 1'b0, 2'd2, 1'b0, 32'h1122_3344, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1};
        vecs[10] = '{32'h8000_0003, 32'h0000_BEEF, 1'b1, 2'd1, 1'b0, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1};
`else
        vecs[9]  = '{32'h8000_0001, 32'h0000_0000, 1'b0, 2'd2, 1'b0, 32'h1122_3344, 32'h0011_2233, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 4'b0000, 32'h0000_0000, 3};
        vecs[10] = '{32'h8000_0003, 32'h0000_BEEF, 1'b1, 2'd1, 1'b0, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b1000, 32'hEF00_0000, 3};
`endif

        rst = 1'b1;
        req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wen = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; rsp_ready = 1'b1;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) tick();
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.mem_valid", 32'(mem_valid), 32'd0);
        check("rst.mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        #1;
        check("rst.ready_after", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], 0, 0, $sformatf("v%0d", i));
        end

        run_vec(vecs[0], 0, 10, "bp");

        // No mem_ready ever: abort after the timeout, later beats are ignored.
        tv = '{32'h8000_0010, 32'h0, 1'b0, 2'd2, 1'b0, 32'h1111_1111, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8000_0010, 4'b1111, 32'h0, TIMEOUT_CYC + 2};
        run_vec(tv, 1, 0, "tmo");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stale.rsp_valid", 32'(rsp_valid), 32'd0);
            check("stale.req_ready", 32'(req_ready), 32'd1);
        end
        mem_rvalid = 1'b0;

        // Beat arriving on the timeout cycle completes normally.
        tv = '{32'h8000_0014, 32'h0, 1'b0, 2'd2, 1'b0, 32'h7777_8888, 32'h7777_8888, 1'b0, 1'b1, 1'b1, 32'h8000_0014, 4'b1111, 32'h0, TIMEOUT_CYC + 2};
        run_vec(tv, 2, 0, "race");

        // Reset while waiting for the beat: nothing comes back.
        req_valid = 1'b1; req_addr = 32'h8000_0020; req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        tick();
        req_valid = 1'b0;
        sb.push_back('{32'h0, 1'b0});
        check("rstw.mem_valid", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("rstw.in_wait", 32'(mem_valid | req_ready | rsp_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("rstw.ready_low", 32'(req_ready), 32'd0);
        tick();
        sb.delete();
        check("rstw.rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h9999_9999;
        #1;
        check("rstw.idle", 32'(req_ready), 32'd1);
        tick();
        mem_rvalid = 1'b0;
        check("rstw.no_rsp", 32'(rsp_valid), 32'd0);
        check("rstw.still_idle", 32'(req_ready), 32'd1);

        run_vec(vecs[1], 0, 0, "post");
        check("sb.drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
